// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: data-register FSM states and counter sizing helper.
package jtag_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } confreg_state_e;

    // Bit-count width able to hold 0..dr_width+1 (one past legal for saturation).
    function automatic int unsigned cnt_width(input int unsigned dr_width);
        return $clog2(dr_width + 2);
    endfunction

endpackage

// File: rtl/jtag_shift_chain.sv
// Parallel-load, LSB-first serial shift chain for a JTAG data register.
module jtag_shift_chain #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             scan_in_i,
    output logic [WIDTH-1:0] data_o,
    output logic             scan_out_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = load_data_i;
        end else if (shift_i) begin
            shreg_d = {scan_in_i, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign data_o     = shreg_q;
    assign scan_out_o = shreg_q[0];

endmodule

// File: rtl/jtag_confreg.sv
// JTAG configuration DR: commits the shifted word only after exactly DR_WIDTH
// shifts since the last capture; otherwise flags a sticky length error.
module jtag_confreg
    import jtag_pkg::*;
#(
    parameter int unsigned          DR_WIDTH    = 32,
    parameter logic [DR_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                tck_i,
    input  logic                rst_i,
    input  logic                sel_i,
    input  logic                capture_dr_i,
    input  logic                shift_dr_i,
    input  logic                update_dr_i,
    input  logic                scan_in_i,
    output logic                scan_out_o,
    input  logic [DR_WIDTH-1:0] status_i,
    output logic [DR_WIDTH-1:0] conf_o,
    output logic                conf_valid_o,
    output logic                len_err_o,
    output confreg_state_e      state_o
);

    localparam int unsigned   CW       = cnt_width(DR_WIDTH);
    localparam logic [CW-1:0] CNT_LEN  = CW'(DR_WIDTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DR_WIDTH + 1);

    confreg_state_e      state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DR_WIDTH-1:0] conf_q, conf_d;
    logic                valid_q, err_q, err_d;
    logic [DR_WIDTH-1:0] shreg;
    logic                chain_out;
    logic                cap_w, shift_w, upd_w;
    logic                commit, upd_err;

    // Strobe priority: capture > shift > update, all gated by select.
    assign cap_w   = sel_i & capture_dr_i;
    assign shift_w = sel_i & shift_dr_i & ~capture_dr_i;
    assign upd_w   = sel_i & update_dr_i & ~capture_dr_i & ~shift_dr_i;

    jtag_shift_chain #(.WIDTH(DR_WIDTH)) u_chain (
        .clk_i       (tck_i),
        .rst_i       (rst_i),
        .load_i      (cap_w),
        .shift_i     (shift_w),
        .load_data_i (status_i),
        .scan_in_i   (scan_in_i),
        .data_o      (shreg),
        .scan_out_o  (chain_out)
    );

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cap_w) begin
            state_d = ARMED;
        end else if (shift_w && (state_q != IDLE)) begin
            state_d = SHIFT;
        end else if (upd_w) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        commit  = upd_w && (state_q == SHIFT) && (cnt_q == CNT_LEN);
        upd_err = upd_w && !commit;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cap_w) begin
            cnt_d = '0;
        end else if (shift_w && (state_q != IDLE) && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + 1'b1;
        end
        conf_d = commit ? shreg : conf_q;
        err_d  = err_q;
        if (commit) begin
            err_d = 1'b0;
        end else if (upd_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            conf_q  <= RESET_VALUE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            conf_q  <= conf_d;
            valid_q <= commit;
            err_q   <= err_d;
        end
    end

    assign scan_out_o   = sel_i & chain_out;
    assign conf_o       = conf_q;
    assign conf_valid_o = valid_q;
    assign len_err_o    = err_q;
    assign state_o      = state_q;

endmodule

// File: doc/jtag_confreg.md
# jtag_confreg

JTAG configuration data register that sits directly downstream of the TAP controller (`tap_top`). It consumes the TAP's `confreg_sel`, `capture_dr`, `shift_dr`, `update_dr` and `scan_in` outputs and returns serial data on the TAP's `confreg_out` input. A DR-scan commits a new configuration word only when exactly `DR_WIDTH` bits were shifted since the last capture. The block runs entirely in the TCK domain.

## Interface
- `DR_WIDTH`, default 32: length of the shift chain and of the configuration word (≥2).
- `RESET_VALUE`, default `'0`: value of `conf_o` after reset.
- `tck_i`  in  1  JTAG test clock; the only clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `sel_i`  in  1  DR select from the TAP (confreg selected by IR).
- `capture_dr_i`  in  1  TAP Capture-DR strobe.
- `shift_dr_i`  in  1  TAP Shift-DR strobe.
- `update_dr_i`  in  1  TAP Update-DR strobe.
- `scan_in_i`  in  1  serial data from the TAP (TDI).
- `scan_out_o`  out  1  serial data to the TAP (`confreg_out_i` on the TAP).
- `status_i`  in  DR_WIDTH  word loaded into the chain on capture.
- `conf_o`  out  DR_WIDTH  committed configuration word.
- `conf_valid_o`  out  1  one-cycle pulse when `conf_o` changes through a commit.
- `len_err_o`  out  1  sticky: the last update saw a wrong shift count or no capture.

## Operation
- Strobes act only while `sel_i`=1. With `sel_i`=0 all strobes are ignored and the FSM holds its state.
- FSM states:
  - IDLE, the reset state.
  - ARMED, entered after capture.
  - SHIFT, entered after the first shift.
- Capture, from any state:
  - `shreg` ← `status_i`.
  - `cnt` ← 0.
  - State → ARMED.
- Shift, in ARMED or SHIFT:
  - `shreg` ← {`scan_in_i`, `shreg[DR_WIDTH-1:1]`}, LSB first out.
  - `cnt` ← `cnt`+1, saturating at DR_WIDTH+1.
  - State → SHIFT.
- Shift in IDLE: `shreg` shifts, `cnt` unchanged (stays 0), state stays IDLE.
- Update in SHIFT with `cnt`==DR_WIDTH (commit):
  - `conf_o` ← `shreg`.
  - `conf_valid_o` pulses.
  - `len_err_o` ← 0.
- Update in SHIFT with `cnt`≠DR_WIDTH, or update in ARMED or IDLE:
  - No commit; `conf_o` is unchanged.
  - `len_err_o` ← 1.
- After any update, state → IDLE.
- Simultaneous strobes are illegal from a real TAP but defined here: priority is capture > shift > update. Only the winner takes effect.
- `scan_out_o` = `shreg[0]` whenever `sel_i`=1, else 0. It is combinational from the register, so the TAP's negedge TDO flop samples it.
- `cnt` width is $clog2(DR_WIDTH+2). Saturation prevents wrap-around, so an over-long shift never aliases to a legal count.

## Timing
- All state updates happen on the rising edge of `tck_i`.
- The strobe sampled at edge N takes effect at edge N.
- Commit latency:
  - `conf_o` updates at the edge that samples `update_dr_i`.
  - `conf_valid_o` is high for exactly the following cycle (registered).
- Serial-out timing: the first bit on `scan_out_o` is `status_i[0]`, valid from the capture edge until the first shift edge.
- Reset (`rst_i`=1, asynchronous assert; internally synchronised de-assert is not required in this block):
  - `shreg`=0, `cnt`=0, state IDLE.
  - `conf_o`=RESET_VALUE, `conf_valid_o`=0, `len_err_o`=0, `scan_out_o`=0.
- Reset mid-shift aborts the scan: no commit, and no error is flagged.

## Structure
- Shared package `jtag_pkg`: FSM state enum `confreg_state_e` {IDLE, ARMED, SHIFT} and a localparam helper for the counter width. The TAP and later DRs reuse these.
- One natural sub-module: `jtag_shift_chain`, holding the `shreg` with parallel load, serial shift and serial out, parameterised by width. The FSM, counter and commit logic stay in `jtag_confreg`.

## Test plan
All scenarios use DR_WIDTH=8.

- Reset: assert `rst_i` with no clock. Required: `conf_o`=RESET_VALUE, `conf_valid_o`=0, `len_err_o`=0, `scan_out_o`=0 immediately.
- Legal scan: `status_i`=8'hA5; capture; shift 8 bits of 8'h3C LSB-first; update. Required:
  - `scan_out_o` yields 1,0,1,0,0,1,0,1.
  - `conf_o`=8'h3C.
  - `conf_valid_o` high for 1 cycle.
  - `len_err_o`=0.
- Short and long scans: capture then 7 shifts then update → `conf_o` unchanged, `len_err_o`=1. Capture then 12 shifts then update → no commit, `len_err_o`=1. A following legal scan of 8'h81 → `conf_o`=8'h81, `len_err_o`=0.
- Deselect: `sel_i`=0 during 8 shift strobes and an update. Required: no state change, `scan_out_o`=0, no `conf_valid_o`. An update with no preceding capture → `len_err_o`=1.
- Simultaneous strobes: capture+update in the same cycle → capture wins, state ARMED, no commit. Shift+update → shift wins.
- Reset mid-shift: assert `rst_i` after 4 shifts, then run a legal scan of 8'h55. Required: `conf_o`=RESET_VALUE until that scan's update, then 8'h55. `len_err_o` stays 0 throughout.
